// File: rtl/ysyx_22040895_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_22040895_lsu
//
// Purpose:
//    Load/store stage that sits directly after the execute unit. Each
//    accepted instruction either passes its ALU result straight through to
//    write-back, or performs exactly one data-memory access over a
//    req/gnt/rvalid bus and returns the (extended) load data, or zero for a
//    store.
//
// Ports:
//    clk, rst                 single rising-edge clock, synchronous active-high reset
//    valid_i_lsu/ready_o_lsu  EXU -> LSU handshake
//    mem_en_i_lsu             1 = load/store, 0 = pass-through
//    memop_i_lsu              [3] store, [2] unsigned load, [1:0] size B/H/W/D
//    addr_i_lsu               effective address or ALU result
//    wdata_i_lsu              store data
//    rd_i_lsu                 destination register, echoed on rd_o_lsu
//    dmem_*                   data-memory request/response bus
//    valid_o_lsu/ready_i_lsu  LSU -> WBU handshake
//    wbdata_o_lsu             write-back data
//    rd_o_lsu                 destination register
//    misalign_o_lsu           misaligned access flag, qualified by valid_o_lsu
//
// Configuration:
//    YSYX_22040895_LSU_MISALIGN_CHECK_EN
//       defined   : misaligned memory ops complete immediately with
//                   misalign_o_lsu=1, wbdata=0 and no bus request.
//       undefined : misalign_o_lsu is 0 and the byte offset is rounded down
//                   to the natural alignment of the access size.
// ---------------------------------------------------------------------------
module ysyx_22040895_lsu #(
   parameter int XLEN   = 64,
   parameter int RIDX_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i_lsu,
   output logic              ready_o_lsu,
   input  logic              mem_en_i_lsu,
   input  logic [3:0]        memop_i_lsu,
   input  logic [XLEN-1:0]   addr_i_lsu,
   input  logic [XLEN-1:0]   wdata_i_lsu,
   input  logic [RIDX_W-1:0] rd_i_lsu,
   output logic              dmem_req_o_lsu,
   output logic              dmem_we_o_lsu,
   output logic [XLEN-1:0]   dmem_addr_o_lsu,
   output logic [XLEN-1:0]   dmem_wdata_o_lsu,
   output logic [7:0]        dmem_wmask_o_lsu,
   input  logic              dmem_gnt_i_lsu,
   input  logic              dmem_rvalid_i_lsu,
   input  logic [XLEN-1:0]   dmem_rdata_i_lsu,
   output logic              valid_o_lsu,
   input  logic              ready_i_lsu,
   output logic [XLEN-1:0]   wbdata_o_lsu,
   output logic [RIDX_W-1:0] rd_o_lsu,
   output logic              misalign_o_lsu
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t              state_q,      state_d;
   logic [3:0]          memop_q,      memop_d;
   logic [2:0]          off_q,        off_d;
   logic [RIDX_W-1:0]   rd_q,         rd_d;
   logic [XLEN-1:0]     wbdata_q,     wbdata_d;
   logic                misalign_q,   misalign_d;
   logic [XLEN-1:0]     req_addr_q,   req_addr_d;
   logic [XLEN-1:0]     req_wdata_q,  req_wdata_d;
   logic [7:0]          req_wmask_q,  req_wmask_d;

   logic                accept;
   logic [2:0]          size_mask;
   logic [2:0]          off_in;
   logic [7:0]          lane_ones;
   logic                misaligned_in;
   logic [XLEN-1:0]     rdata_shifted;
   logic [XLEN-1:0]     load_data;
   logic                sign_ext;

   // Handshake towards the EXU: a new instruction can be taken when idle, or
   // when the current result is leaving in this very cycle.
   always_comb begin
      ready_o_lsu = (state_q == IDLE) | ((state_q == RESP) & ready_i_lsu);
      accept      = valid_i_lsu & ready_o_lsu;
   end

   // Decode the incoming access: alignment mask and byte lanes touched by
   // an access of the requested size.
   always_comb begin
      size_mask = 3'd0;
      lane_ones = 8'h01;
      case (memop_i_lsu[1:0])
         2'd0: begin size_mask = 3'd0; lane_ones = 8'h01; end
         2'd1: begin size_mask = 3'd1; lane_ones = 8'h03; end
         2'd2: begin size_mask = 3'd3; lane_ones = 8'h0F; end
         default: begin size_mask = 3'd7; lane_ones = 8'hFF; end
      endcase
`ifdef YSYX_22040895_LSU_MISALIGN_CHECK_EN
      misaligned_in = (addr_i_lsu[2:0] & size_mask) != 3'd0;
      off_in        = addr_i_lsu[2:0];
`else
      misaligned_in = 1'b0;
      off_in        = addr_i_lsu[2:0] & ~size_mask;
`endif
   end

   // Load data extraction: move the addressed lanes down to bit 0 and then
   // sign- or zero-extend according to the recorded memop.
   always_comb begin
      rdata_shifted = dmem_rdata_i_lsu >> {off_q, 3'b000};
      sign_ext      = ~memop_q[2];
      case (memop_q[1:0])
         2'd0: load_data = {{(XLEN-8){sign_ext & rdata_shifted[7]}}, rdata_shifted[7:0]};
         2'd1: load_data = {{(XLEN-16){sign_ext & rdata_shifted[15]}}, rdata_shifted[15:0]};
         2'd2: load_data = {{(XLEN-32){sign_ext & rdata_shifted[31]}}, rdata_shifted[31:0]};
         default: load_data = rdata_shifted;
      endcase
   end

   // Next-state logic. The state-specific part handles the bus and the
   // write-back handshake; a new accept (only possible in IDLE or on a RESP
   // handshake) overrides it at the end.
   always_comb begin
      state_d     = state_q;
      memop_d     = memop_q;
      off_d       = off_q;
      rd_d        = rd_q;
      wbdata_d    = wbdata_q;
      misalign_d  = misalign_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wmask_d = req_wmask_q;

      case (state_q)
         REQ: begin
            if (dmem_gnt_i_lsu) begin
               if (memop_q[3]) begin
                  state_d  = RESP;
                  wbdata_d = '0;
               end else if (dmem_rvalid_i_lsu) begin
                  state_d  = RESP;
                  wbdata_d = load_data;
               end else begin
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            if (dmem_rvalid_i_lsu) begin
               state_d  = RESP;
               wbdata_d = load_data;
            end
         end
         RESP: begin
            if (ready_i_lsu) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      if (accept) begin
         memop_d    = memop_i_lsu;
         off_d      = off_in;
         rd_d       = rd_i_lsu;
         misalign_d = 1'b0;
         if (!mem_en_i_lsu) begin
            state_d  = RESP;
            wbdata_d = addr_i_lsu;
         end else if (misaligned_in) begin
            state_d    = RESP;
            wbdata_d   = '0;
            misalign_d = 1'b1;
         end else begin
            state_d     = REQ;
            req_addr_d  = {addr_i_lsu[XLEN-1:3], 3'b000};
            req_wdata_d = wdata_i_lsu << {off_in, 3'b000};
            req_wmask_d = lane_ones << off_in;
         end
      end
   end

   // State and datapath registers. Reset drops any outstanding request; a
   // response arriving later finds the FSM in IDLE and is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         memop_q     <= '0;
         off_q       <= '0;
         rd_q        <= '0;
         wbdata_q    <= '0;
         misalign_q  <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= '0;
      end else begin
         state_q     <= state_d;
         memop_q     <= memop_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
         wbdata_q    <= wbdata_d;
         misalign_q  <= misalign_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wmask_q <= req_wmask_d;
      end
   end

   // Outputs come straight from registers, qualified by state where the bus
   // or write-back protocol needs it.
   always_comb begin
      dmem_req_o_lsu   = (state_q == REQ);
      dmem_we_o_lsu    = (state_q == REQ) & memop_q[3];
      dmem_addr_o_lsu  = req_addr_q;
      dmem_wdata_o_lsu = req_wdata_q;
      dmem_wmask_o_lsu = req_wmask_q;
      valid_o_lsu      = (state_q == RESP);
      wbdata_o_lsu     = wbdata_q;
      rd_o_lsu         = rd_q;
`ifdef YSYX_22040895_LSU_MISALIGN_CHECK_EN
      misalign_o_lsu   = misalign_q;
`else
      misalign_o_lsu   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040895_lsu
//
// Drives directed and random instructions into the LSU, plays the data
// memory and the WBU, and compares every bus request and write-back result
// against a transaction-level reference model built from byte arithmetic.
// ---------------------------------------------------------------------------
module tb_ysyx_22040895_lsu;

   logic        clock;
   logic        rst;
   logic        validIn;
   logic        readyOut;
   logic        memEn;
   logic [3:0]  memop;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [4:0]  rdIn;
   logic        dmemReq;
   logic        dmemWe;
   logic [63:0] dmemAddr;
   logic [63:0] dmemWdata;
   logic [7:0]  dmemWmask;
   logic        dmemGnt;
   logic        dmemRvalid;
   logic [63:0] dmemRdata;
   logic        validOut;
   logic        readyIn;
   logic [63:0] wbData;
   logic [4:0]  rdOut;
   logic        misalign;

   int vectorCount = 0;
   int errorCount  = 0;

   ysyx_22040895_lsu dut (
      .clk               (clock),
      .rst               (rst),
      .valid_i_lsu       (validIn),
      .ready_o_lsu       (readyOut),
      .mem_en_i_lsu      (memEn),
      .memop_i_lsu       (memop),
      .addr_i_lsu        (addr),
      .wdata_i_lsu       (wdata),
      .rd_i_lsu          (rdIn),
      .dmem_req_o_lsu    (dmemReq),
      .dmem_we_o_lsu     (dmemWe),
      .dmem_addr_o_lsu   (dmemAddr),
      .dmem_wdata_o_lsu  (dmemWdata),
      .dmem_wmask_o_lsu  (dmemWmask),
      .dmem_gnt_i_lsu    (dmemGnt),
      .dmem_rvalid_i_lsu (dmemRvalid),
      .dmem_rdata_i_lsu  (dmemRdata),
      .valid_o_lsu       (validOut),
      .ready_i_lsu       (readyIn),
      .wbdata_o_lsu      (wbData),
      .rd_o_lsu          (rdOut),
      .misalign_o_lsu    (misalign)
   );

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectorCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: number of bytes touched by an access size.
   function automatic int accBytes(input logic [1:0] size);
      return 1 << size;
   endfunction

   function automatic bit isMisaligned(input logic [1:0] size, input logic [63:0] a);
      return (int'(a[2:0]) % accBytes(size)) != 0;
   endfunction

   // Byte offset actually used on the bus.
   function automatic int effOff(input logic [1:0] size, input logic [63:0] a);
`ifdef YSYX_22040895_LSU_MISALIGN_CHECK_EN
      return int'(a[2:0]);
`else
      return int'(a[2:0]) - (int'(a[2:0]) % accBytes(size));
`endif
   endfunction

   function automatic logic [7:0] expMask(input logic [1:0] size, input int off);
      logic [7:0] m;
      m = '0;
      for (int b = 0; b < 8; b++) m[b] = (b >= off) && (b < off + accBytes(size));
      return m;
   endfunction

   function automatic logic [63:0] expWdata(input logic [63:0] d, input int off);
      logic [63:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) if (b >= off) r[b*8 +: 8] = d[(b-off)*8 +: 8];
      return r;
   endfunction

   function automatic logic [63:0] expLoad(input logic [63:0] rdata, input logic [3:0] op, input int off);
      logic [63:0] v;
      int n;
      n = accBytes(op[1:0]);
      v = '0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = rdata[(off+i)*8 +: 8];
      if (!op[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      return v;
   endfunction

   // Wait one cycle and land just after the active edge.
   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Runs one complete instruction from IDLE back to IDLE, acting as the
   // memory (gnt after gntDelay cycles, rvalid rvDelay cycles after gnt)
   // and as the WBU (ready after readyDelay cycles).
   task automatic applyStimulus(input logic en, input logic [3:0] op, input logic [63:0] a,
                                input logic [63:0] wd, input logic [4:0] rd,
                                input int gntDelay, input int rvDelay, input int readyDelay,
                                input logic [63:0] rdata);
      bit         misal;
      int         off;
      logic [63:0] expWb;
`ifdef YSYX_22040895_LSU_MISALIGN_CHECK_EN
      misal = en && isMisaligned(op[1:0], a);
`else
      misal = 1'b0;
`endif
      off = effOff(op[1:0], a);
      if (!en)        expWb = a;
      else if (misal) expWb = '0;
      else if (op[3]) expWb = '0;
      else            expWb = expLoad(rdata, op, off);

      validIn = 1'b1; memEn = en; memop = op; addr = a; wdata = wd; rdIn = rd;
      readyIn = 1'b0; dmemGnt = 1'b0; dmemRvalid = 1'b0;
      @(negedge clock);
      checkOutput("ready_idle", {63'd0, readyOut}, 64'd1);
      nextCycle();
      validIn = 1'b0;

      if (en && !misal) begin
         for (int k = 0; k <= gntDelay; k++) begin
            dmemGnt    = (k == gntDelay);
            dmemRvalid = (k == gntDelay) && !op[3] && (rvDelay == 0);
            dmemRdata  = rdata;
            @(negedge clock);
            checkOutput("req",   {63'd0, dmemReq},  64'd1);
            checkOutput("we",    {63'd0, dmemWe},   {63'd0, op[3]});
            checkOutput("daddr", dmemAddr,          {a[63:3], 3'b000});
            checkOutput("wmask", {56'd0, dmemWmask}, {56'd0, expMask(op[1:0], off)});
            if (op[3]) checkOutput("dwdata", dmemWdata, expWdata(wd, off));
            checkOutput("valid_req", {63'd0, validOut}, 64'd0);
            nextCycle();
         end
         dmemGnt = 1'b0; dmemRvalid = 1'b0;
         if (!op[3] && rvDelay > 0) begin
            for (int k = 1; k <= rvDelay; k++) begin
               dmemRvalid = (k == rvDelay);
               dmemRdata  = (k == rvDelay) ? rdata : 64'(~rdata);
               @(negedge clock);
               checkOutput("req_wait", {63'd0, dmemReq}, 64'd0);
               checkOutput("valid_wait", {63'd0, validOut}, 64'd0);
               nextCycle();
            end
            dmemRvalid = 1'b0;
         end
      end

      for (int k = 0; k <= readyDelay; k++) begin
         readyIn = (k == readyDelay);
         @(negedge clock);
         checkOutput("valid", {63'd0, validOut}, 64'd1);
         checkOutput("wbdata", wbData, expWb);
         checkOutput("rd", {59'd0, rdOut}, {59'd0, rd});
         checkOutput("misalign", {63'd0, misalign}, {63'd0, misal});
         checkOutput("req_resp", {63'd0, dmemReq}, 64'd0);
         checkOutput("ready_resp", {63'd0, readyOut}, {63'd0, readyIn});
         nextCycle();
      end
      readyIn = 1'b0;
      @(negedge clock);
      checkOutput("valid_done", {63'd0, validOut}, 64'd0);
      nextCycle();
   endtask

   initial begin
      rst = 1'b1; validIn = 1'b0; memEn = 1'b0; memop = '0; addr = '0; wdata = '0;
      rdIn = '0; dmemGnt = 1'b0; dmemRvalid = 1'b0; dmemRdata = '0; readyIn = 1'b0;
      nextCycle();
      nextCycle();
      @(negedge clock);
      checkOutput("rst_ready", {63'd0, readyOut}, 64'd1);
      checkOutput("rst_valid", {63'd0, validOut}, 64'd0);
      checkOutput("rst_req", {63'd0, dmemReq}, 64'd0);
      checkOutput("rst_wbdata", wbData, 64'd0);
      checkOutput("rst_wmask", {56'd0, dmemWmask}, 64'd0);
      checkOutput("rst_misalign", {63'd0, misalign}, 64'd0);
      rst = 1'b0;
      nextCycle();

      // Pass-through, signed byte load, store half, stall, misaligned word.
      applyStimulus(1'b0, 4'b0000, 64'h1234, 64'd0, 5'd7, 0, 0, 0, 64'd0);
      applyStimulus(1'b1, 4'b0000, 64'h8000_0003, 64'd0, 5'd9, 0, 0, 0, 64'h0000_0000_8000_0000);
      applyStimulus(1'b1, 4'b1001, 64'h8000_0006, 64'hBEEF, 5'd0, 0, 0, 0, 64'd0);
      applyStimulus(1'b1, 4'b0011, 64'h8000_1000, 64'd0, 5'd12, 3, 2, 2, 64'h0123_4567_89AB_CDEF);
      applyStimulus(1'b1, 4'b0010, 64'h8000_2002, 64'd0, 5'd3, 0, 0, 0, 64'hCAFE_F00D_8765_4321);
      applyStimulus(1'b1, 4'b1010, 64'h8000_2002, 64'h1122_3344, 5'd3, 1, 0, 0, 64'd0);

      // Back-to-back pass-through: accept the second in the first's RESP.
      validIn = 1'b1; memEn = 1'b0; memop = '0; addr = 64'hAAAA; rdIn = 5'd3; readyIn = 1'b1;
      @(negedge clock);
      checkOutput("b2b_ready0", {63'd0, readyOut}, 64'd1);
      nextCycle();
      addr = 64'hBBBB; rdIn = 5'd4;
      @(negedge clock);
      checkOutput("b2b_valid1", {63'd0, validOut}, 64'd1);
      checkOutput("b2b_wb1", wbData, 64'hAAAA);
      checkOutput("b2b_ready1", {63'd0, readyOut}, 64'd1);
      nextCycle();
      validIn = 1'b0;
      @(negedge clock);
      checkOutput("b2b_valid2", {63'd0, validOut}, 64'd1);
      checkOutput("b2b_wb2", wbData, 64'hBBBB);
      checkOutput("b2b_rd2", {59'd0, rdOut}, 64'd4);
      nextCycle();
      readyIn = 1'b0;
      @(negedge clock);
      checkOutput("b2b_idle", {63'd0, validOut}, 64'd0);
      nextCycle();

      // Reset while waiting for read data; the late rvalid must be dropped.
      validIn = 1'b1; memEn = 1'b1; memop = 4'b0011; addr = 64'h100; rdIn = 5'd5;
      nextCycle();
      validIn = 1'b0; dmemGnt = 1'b1;
      @(negedge clock);
      checkOutput("rst_mid_req", {63'd0, dmemReq}, 64'd1);
      nextCycle();
      dmemGnt = 1'b0;
      @(negedge clock);
      checkOutput("rst_mid_wait", {63'd0, dmemReq}, 64'd0);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      @(negedge clock);
      checkOutput("rst_mid_ready", {63'd0, readyOut}, 64'd1);
      checkOutput("rst_mid_valid", {63'd0, validOut}, 64'd0);
      dmemRvalid = 1'b1; dmemRdata = 64'hDEAD_BEEF_DEAD_BEEF;
      nextCycle();
      dmemRvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checkOutput("rst_mid_late", {63'd0, validOut}, 64'd0);
         nextCycle();
      end

      // Random instructions with random bus and write-back timing.
      for (int n = 0; n < 80; n++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), {$urandom, $urandom},
                       {$urandom, $urandom}, 5'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                       {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
      $finish;
   end

endmodule
